// File: rtl/spi_slave_if.sv
// Signal bundle between spi_slave and its environment: the SPI pins plus the
// fabric-side TX holding register and RX strobe.
interface spi_slave_if;
    logic       nCS;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       miso_oe;
    logic       CPOL;
    logic       CPHA;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       underrun;
    logic       frame_err;

    // The master side combines the external SPI master and the host logic.
    modport master (
        output nCS, SCLK, MOSI, CPOL, CPHA, tx_wr, tx_data,
        input  MISO, miso_oe, tx_full, rx_valid, rx_data, busy, underrun, frame_err
    );

    modport slave (
        input  nCS, SCLK, MOSI, CPOL, CPHA, tx_wr, tx_data,
        output MISO, miso_oe, tx_full, rx_valid, rx_data, busy, underrun, frame_err
    );
endinterface

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave for all four CPOL/CPHA modes, oversampled in the clk domain.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first; the default build is MSB first.
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
    input logic        clk,
    input logic        rst,
    spi_slave_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ncs_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ncs_prev;
    logic                   sclk_prev;

    logic [1:0] state;
    logic       cpol_q;
    logic       cpha_q;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] tx_next;
    logic [7:0] rx_shift;
    logic [7:0] rx_next;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       underrun_q;
    logic       frame_err_q;
    logic [7:0] tx_hold;
    logic       tx_full_q;

    logic ncs_fall;
    logic sclk_toggle;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic load_take;

    // NOTE: the synchronizers reset to the deselected bus levels, so leaving reset never fakes a select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync  <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ncs_prev  <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.nCS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            ncs_prev  <= ncs_s;
            sclk_prev <= sclk_s;
        end
    end

    assign ncs_s  = ncs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ncs_fall    = ncs_prev & ~ncs_s;
    assign sclk_toggle = sclk_s ^ sclk_prev;
    assign lead_edge   = sclk_toggle & (sclk_s != cpol_q);
    assign trail_edge  = sclk_toggle & (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    // With no bit sampled yet in this byte, a shift edge would push the freshly loaded
    // MSB away (CPHA=1 first leading edge, CPHA=0 trailing edge after a byte completes).
    assign shift_edge  = (cpha_q ? lead_edge : trail_edge) & (bit_cnt != 3'd0);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next  = {mosi_s, rx_shift[7:1]};
    assign tx_next  = {1'b1, tx_shift[7:1]};
    assign bus.MISO = tx_shift[0];
`else
    assign rx_next  = {rx_shift[6:0], mosi_s};
    assign tx_next  = {tx_shift[6:0], 1'b1};
    assign bus.MISO = tx_shift[7];
`endif

    assign load_take = (state == LOAD) & ~ncs_s & tx_full_q;

    // A write always wins over the LOAD hand-off, so a byte written in the LOAD clk stays held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_hold   <= 8'h00;
            tx_full_q <= 1'b0;
        end else if (bus.tx_wr) begin
            tx_hold   <= bus.tx_data;
            tx_full_q <= 1'b1;
        end else if (load_take) begin
            tx_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= 3'd0;
            tx_shift    <= 8'hFF;
            rx_shift    <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: strobes default low every clk; the branches below raise them for one cycle only.
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (ncs_fall) begin
                cpol_q <= bus.CPOL;
                cpha_q <= bus.CPHA;
            end

            case (state)
                IDLE: begin
                    if (ncs_fall) state <= LOAD;
                end
                LOAD: begin
                    if (ncs_s) begin
                        state <= IDLE;
                    end else begin
                        tx_shift   <= tx_full_q ? tx_hold : DEFAULT_TX;
                        underrun_q <= ~tx_full_q;
                        bit_cnt    <= 3'd0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ncs_s) begin
                        frame_err_q <= (bit_cnt != 3'd0);
                        state       <= IDLE;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                            state      <= LOAD;
                        end
                    end else if (shift_edge) begin
                        tx_shift <= tx_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso_oe   = ~ncs_s;
    assign bus.busy      = (state != IDLE);
    assign bus.tx_full   = tx_full_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.underrun  = underrun_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master plus a frame-level
// model of the TX holding register, the received bytes and the strobes.
`timescale 1ns/1ps
module tb_spi_slave;
    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] DEFAULT_TX  = 8'hFF;
    localparam int         HALF        = 8;    // SCLK half period in clk cycles

    logic clk = 1'b0;
    logic rst;

    spi_slave_if bus();

    spi_slave #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEFAULT_TX (DEFAULT_TX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed strobes, collected away from the active edge.
    logic [7:0] rx_q[$];
    int         under_cnt = 0;
    int         ferr_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid)  rx_q.push_back(bus.rx_data);
            if (bus.underrun)  under_cnt++;
            if (bus.frame_err) ferr_cnt++;
        end
    end

    // Reference model: the holding register as a value plus an occupied flag.
    logic [7:0] m_hold;
    logic       m_full;
    int         exp_under;
    logic [7:0] mosi_bytes[4];
    logic [7:0] miso_got[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_load();
        if (m_full) begin
            m_full = 1'b0;
            return m_hold;
        end
        exp_under++;
        return DEFAULT_TX;
    endfunction

    // Bit position carried by the i-th bit on the wire.
    function automatic int wire_idx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    task automatic tx_write(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_wr   = 1'b1;
        @(negedge clk);
        bus.tx_wr   = 1'b0;
        m_hold = d;
        m_full = 1'b1;
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        mosi_bytes[0] = b0;
        mosi_bytes[1] = b1;
        mosi_bytes[2] = b2;
        mosi_bytes[3] = b3;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":MISO"},      32'(bus.MISO),      32'd1);
        check({name, ":miso_oe"},   32'(bus.miso_oe),   32'd0);
        check({name, ":tx_full"},   32'(bus.tx_full),   32'd0);
        check({name, ":rx_valid"},  32'(bus.rx_valid),  32'd0);
        check({name, ":rx_data"},   32'(bus.rx_data),   32'd0);
        check({name, ":busy"},      32'(bus.busy),      32'd0);
        check({name, ":underrun"},  32'(bus.underrun),  32'd0);
        check({name, ":frame_err"}, 32'(bus.frame_err), 32'd0);
    endtask

    // One select period: max_edges SCLK edges, then deselect (or reset when do_reset).
    // co_wr writes co_data in the clk where the DUT is loading its first byte.
    task automatic run_frame(input string name, input logic cpol, input logic cpha,
                             input int nbytes, input int max_edges, input logic co_wr,
                             input logic [7:0] co_data, input logic do_reset);
        logic [7:0] exp_miso[$];
        logic [31:0] rx_seen;
        int   samples, complete, rx_base, under_base, ferr_base, edges, idx;
        logic exp_full_start, stop;

        samples    = cpha ? max_edges / 2 : (max_edges + 1) / 2;
        complete   = samples / 8;
        rx_base    = rx_q.size();
        under_base = under_cnt;
        ferr_base  = ferr_cnt;
        exp_under  = 0;

        // A byte is loaded at select and again after every completed byte.
        exp_miso.push_back(model_load());
        if (co_wr) begin
            m_hold = co_data;
            m_full = 1'b1;
        end
        exp_full_start = m_full;
        for (int k = 0; k < complete; k++) exp_miso.push_back(model_load());

        for (int b = 0; b < 4; b++) miso_got[b] = 8'h00;
        bus.CPOL = cpol;
        bus.CPHA = cpha;
        bus.SCLK = cpol;
        bus.MOSI = 1'b0;
        wait_clk(4);
        bus.nCS = 1'b0;
        if (co_wr) begin
            for (int k = 0; k < 20 && !bus.busy; k++) @(negedge clk);
            check({name, ":load_seen"}, 32'(bus.busy), 32'd1);
            bus.tx_data = co_data;
            bus.tx_wr   = 1'b1;
            @(negedge clk);
            bus.tx_wr   = 1'b0;
        end
        wait_clk(2 * HALF);
        check({name, ":busy"},    32'(bus.busy),    32'd1);
        check({name, ":miso_oe"}, 32'(bus.miso_oe), 32'd1);
        check({name, ":tx_full_after_load"}, 32'(bus.tx_full), 32'(exp_full_start));

        edges = 0;
        stop  = 1'b0;
        for (int b = 0; b < nbytes && !stop; b++) begin
            for (int i = 0; i < 8 && !stop; i++) begin
                idx = wire_idx(i);
                if (!cpha) begin
                    bus.MOSI = mosi_bytes[b][idx];
                    wait_clk(HALF);
                    miso_got[b][idx] = bus.MISO;
                    bus.SCLK = ~cpol;
                    edges++;
                    if (edges < max_edges) begin
                        wait_clk(HALF);
                        bus.SCLK = cpol;
                        edges++;
                    end
                end else begin
                    bus.SCLK = ~cpol;
                    bus.MOSI = mosi_bytes[b][idx];
                    edges++;
                    wait_clk(HALF);
                    if (edges < max_edges) begin
                        miso_got[b][idx] = bus.MISO;
                        bus.SCLK = cpol;
                        edges++;
                        wait_clk(HALF);
                    end
                end
                if (edges >= max_edges) stop = 1'b1;
            end
        end
        wait_clk(HALF);

        if (do_reset) begin
            rst = 1'b1;
            #1;
            check_reset_outputs({name, ":in_reset"});
            wait_clk(2);
            bus.nCS  = 1'b1;
            bus.SCLK = 1'b0;
            wait_clk(4);
            rst = 1'b0;
            m_full = 1'b0;
            complete = 0;
        end else begin
            bus.nCS = 1'b1;
        end
        wait_clk(2 * HALF);

        check({name, ":rx_count"}, 32'(rx_q.size() - rx_base), 32'(complete));
        for (int b = 0; b < complete; b++) begin
            rx_seen = (rx_base + b < rx_q.size()) ? 32'(rx_q[rx_base + b]) : 32'hDEAD;
            check($sformatf("%s:rx_byte%0d", name, b), rx_seen, 32'(mosi_bytes[b]));
            check($sformatf("%s:miso_byte%0d", name, b), 32'(miso_got[b]), 32'(exp_miso[b]));
        end
        check({name, ":underruns"}, 32'(under_cnt - under_base), 32'(exp_under));
        check({name, ":frame_errs"}, 32'(ferr_cnt - ferr_base),
              32'(!do_reset && (samples % 8 != 0)));
        check({name, ":idle_busy"},    32'(bus.busy),    32'd0);
        check({name, ":idle_miso_oe"}, 32'(bus.miso_oe), 32'd0);
        check({name, ":idle_tx_full"}, 32'(bus.tx_full), 32'(m_full));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       rc, rp;
        int         nb;
        rst         = 1'b1;
        bus.nCS     = 1'b1;
        bus.SCLK    = 1'b0;
        bus.MOSI    = 1'b0;
        bus.CPOL    = 1'b0;
        bus.CPHA    = 1'b0;
        bus.tx_wr   = 1'b0;
        bus.tx_data = 8'h00;
        m_hold      = 8'h00;
        m_full      = 1'b0;
        exp_under   = 0;

        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(4);

        tx_write(8'h3C);
        check("tx_full_set", 32'(bus.tx_full), 32'd1);
        set_bytes(8'hA5, 8'h00, 8'h00, 8'h00);
        run_frame("mode0", 1'b0, 1'b0, 1, 16, 1'b0, 8'h00, 1'b0);

        tx_write(8'h5A);
        set_bytes(8'h12, 8'h34, 8'h00, 8'h00);
        run_frame("mode3_b2b", 1'b1, 1'b1, 2, 32, 1'b0, 8'h00, 1'b0);

        tx_write(8'h7E);
        set_bytes(8'h81, 8'h00, 8'h00, 8'h00);
        run_frame("mode1", 1'b0, 1'b1, 1, 16, 1'b0, 8'h00, 1'b0);
        tx_write(8'h7E);
        run_frame("mode2", 1'b1, 1'b0, 1, 16, 1'b0, 8'h00, 1'b0);

        set_bytes(8'($urandom), 8'h00, 8'h00, 8'h00);
        run_frame("abort", 1'b0, 1'b0, 1, 5, 1'b0, 8'h00, 1'b0);
        tx_write(8'($urandom));
        set_bytes(8'hC3, 8'h00, 8'h00, 8'h00);
        run_frame("after_abort", 1'b0, 1'b0, 1, 16, 1'b0, 8'h00, 1'b0);

        tx_write(8'h11);
        tx_write(8'h22);
        set_bytes(8'($urandom), 8'h00, 8'h00, 8'h00);
        run_frame("overwrite", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1, 16, 1'b0, 8'h00, 1'b0);

        tx_write(8'h44);
        set_bytes(8'($urandom), 8'h00, 8'h00, 8'h00);
        run_frame("coincident", 1'b0, 1'b0, 1, 16, 1'b1, 8'h55, 1'b0);

        tx_write(8'($urandom));
        set_bytes(8'($urandom), 8'h00, 8'h00, 8'h00);
        run_frame("reset_mid", 1'b0, 1'b0, 1, 7, 1'b0, 8'h00, 1'b1);
        set_bytes(8'h69, 8'h00, 8'h00, 8'h00);
        run_frame("after_reset", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1, 16, 1'b0, 8'h00, 1'b0);

        for (int t = 0; t < 8; t++) begin
            rc = 1'($urandom_range(0, 1));
            rp = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            run_frame($sformatf("rand%0d", t), rc, rp, nb, 16 * nb, 1'b0, 8'h00, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
